aes_block_ctrl: RTL
===================

Name: aes_block_ctrl

Overview:
- Top-level sequencer for the AES path between a byte stream (UART RX/TX side) and a 128-bit AES core.
- Assembles the first 16 received bytes into the key register and every following 16 bytes into a data block.
- Starts the core on each complete data block, waits for completion, then serializes the 128-bit result back out one byte at a time.
- Key is retained across blocks until a key reload is requested.

Parameters:
- AES_TIMEOUT, 1024: max cycles in WAIT_AES before aborting; 0 disables the check.
- IDLE_TIMEOUT, 50000: inter-byte gap limit in cycles (used only with BYTE_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_byte valid.
- key_reload  in  1  pulse; next 16 bytes become the new key.
- aes_key  out  128  key to core.
- aes_data  out  128  plaintext/ciphertext block to core.
- aes_start  out  1  one-cycle start pulse to core.
- aes_done  in  1  core completion strobe.
- aes_result  in  128  core output, valid when aes_done=1.
- tx_byte  out  8  byte to transmitter.
- tx_valid  out  1  tx_byte valid; held until accepted.
- tx_ready  in  1  transmitter accepts when tx_valid & tx_ready.
- busy  out  1  high in any state other than LOAD_KEY/LOAD_DATA with count 0.
- err  out  1  sticky error (overrun or timeout); cleared only by Rst.

Behaviour:
- Reset (async): state=LOAD_KEY, byte count=0, aes_key=0, aes_data=0, result buffer=0, aes_start=0, tx_byte=0, tx_valid=0, busy=0, err=0, timers=0.
- Byte packing: shift-left assembly; first byte received lands in [127:120], 16th in [7:0]. 5-bit counter 0..16.
- LOAD_KEY: each rx_valid shifts into the key shadow and increments the count. When the 16th byte is taken, aes_key updates on the same edge; count->0; go to LOAD_DATA.
- LOAD_DATA: same packing into aes_data. When the 16th byte is taken, go to START.
- key_reload in LOAD_DATA: count->0 and the partial block is discarded; go to LOAD_KEY. key_reload in any other state is latched as pending and applied on the return to LOAD_DATA.
- START: aes_start=1 for exactly one cycle; go to WAIT_AES.
- WAIT_AES:
  - On aes_done, capture aes_result into the result buffer, reset the byte index to 0, and go to SEND.
  - If AES_TIMEOUT≠0 and AES_TIMEOUT cycles elapse without aes_done: set err, go to LOAD_DATA with count 0.
- SEND:
  - tx_byte = result[127-8*i -: 8], tx_valid=1.
  - On tx_valid&tx_ready, i increments.
  - After the handshake for i=15, tx_valid drops the next cycle; go to LOAD_DATA, or LOAD_KEY if a reload is pending.
  - tx_byte/tx_valid change only after a handshake, never while a byte is stalled.
- Overrun: rx_valid in START, WAIT_AES or SEND drops the byte and sets err.
- Simultaneous events:
  - rx_valid and key_reload in the same cycle in LOAD_DATA: reload wins and the byte is dropped.
  - aes_done on the same cycle the timeout expires: aes_done wins.
- Latency: last rx byte to aes_start is 1 cycle (START state). aes_done to first tx_valid is 1 cycle.
- Reset mid-operation aborts everything immediately. Outputs return to their reset values and the key is lost.

Optional Feature:
- Macro: BYTE_TIMEOUT_EN.
- Defined: in LOAD_KEY/LOAD_DATA with count>0, a gap counter reloads on each rx_valid. If IDLE_TIMEOUT cycles pass with no byte, the partial block is discarded, count->0, and err is set. State is unchanged, and a partial key never updates aes_key.
- Not defined: no gap counter; a partial block waits indefinitely.

Test Plan:
- Key then data: send 00..0F, then 00112233445566778899AABBCCDDEEFF; stub core returns 69C4E0D86A7B0430D8CDB78070B4C55A after 10 cycles → aes_key=000102..0F, aes_data as sent, one aes_start pulse, tx emits 69,C4,…,5A in order, then busy=0.
- Key reuse: a second 16-byte block without reload → no key bytes needed, aes_key unchanged, second aes_start issued.
- TX backpressure: hold tx_ready=0 for 20 cycles at byte 3 → tx_byte stays at byte 3 value with tx_valid=1; all 16 bytes are sent exactly once.
- Overrun and timeout: rx_valid during WAIT_AES → err=1 and the byte is ignored. With no aes_done for AES_TIMEOUT=16 → err=1 and state returns to LOAD_DATA.
- Reload: key_reload after 5 data bytes → partial block discarded; next 16 bytes change aes_key, and no aes_start occurs for them.
- Async reset asserted mid-SEND (between clock edges) → tx_valid=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aes_block_ctrl.sv
// Byte-stream sequencer for a 128-bit AES core: packs key/data bytes, starts the core, serializes the result.
// Optional macro BYTE_TIMEOUT_EN adds an inter-byte gap timeout while a key or data block is partially loaded.
module aes_block_ctrl #(
  parameter int unsigned AES_TIMEOUT  = 1024,
  parameter int unsigned IDLE_TIMEOUT = 50000
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         key_reload,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         err,
  output logic [2:0]   dbg_state
);

  // tx is valid/ready: a byte moves on a rising edge with tx_valid & tx_ready both high;
  // tx_byte/tx_valid are held unchanged while tx_ready is low.
  typedef enum logic [2:0] {
    S_LOAD_KEY  = 3'd0,
    S_LOAD_DATA = 3'd1,
    S_START     = 3'd2,
    S_WAIT_AES  = 3'd3,
    S_SEND      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [119:0]  key_sh_q, key_sh_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  res_q, res_d;
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   aes_tmr_q, aes_tmr_d;
  logic          reload_q, reload_d;
  logic          err_q, err_d;
`ifdef BYTE_TIMEOUT_EN
  logic [31:0]   gap_q, gap_d;
`else
  logic          unused_idle_cfg;
  assign unused_idle_cfg = (IDLE_TIMEOUT != 0);
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_LOAD_KEY;
      cnt_q     <= '0;
      key_sh_q  <= '0;
      key_q     <= '0;
      data_q    <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      aes_tmr_q <= '0;
      reload_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef BYTE_TIMEOUT_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_sh_q  <= key_sh_d;
      key_q     <= key_d;
      data_q    <= data_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      aes_tmr_q <= aes_tmr_d;
      reload_q  <= reload_d;
      err_q     <= err_d;
`ifdef BYTE_TIMEOUT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_sh_d  = key_sh_q;
    key_d     = key_q;
    data_d    = data_q;
    res_d     = res_q;
    idx_d     = idx_q;
    aes_tmr_d = aes_tmr_q;
    reload_d  = reload_q;
    err_d     = err_q;
    unique case (state_q)
      S_LOAD_KEY: begin
        // A reload request while already loading the key has nothing left to do.
        if (rx_valid) begin
          key_sh_d = {key_sh_q[111:0], rx_byte};
          if (cnt_q == 5'd15) begin
            key_d   = {key_sh_q, rx_byte};
            cnt_d   = '0;
            state_d = S_LOAD_DATA;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_LOAD_DATA: begin
        if (key_reload) begin
          cnt_d   = '0;
          state_d = S_LOAD_KEY;
        end else if (rx_valid) begin
          data_d = {data_q[119:0], rx_byte};
          if (cnt_q == 5'd15) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_START: begin
        aes_tmr_d = '0;
        state_d   = S_WAIT_AES;
      end
      S_WAIT_AES: begin
        if (aes_done) begin
          res_d   = aes_result;
          idx_d   = '0;
          state_d = S_SEND;
        end else if (AES_TIMEOUT != 0 && aes_tmr_q == 32'(AES_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          cnt_d    = '0;
          reload_d = 1'b0;
          state_d  = (reload_q || key_reload) ? S_LOAD_KEY : S_LOAD_DATA;
        end else begin
          aes_tmr_d = aes_tmr_q + 32'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == 4'd15) begin
            reload_d = 1'b0;
            state_d  = (reload_q || key_reload) ? S_LOAD_KEY : S_LOAD_DATA;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_LOAD_KEY;
    endcase

    // Busy states: bytes are dropped (overrun) and reload requests are deferred.
    if (state_q == S_START || state_q == S_WAIT_AES || state_q == S_SEND) begin
      if (rx_valid) err_d = 1'b1;
      if (key_reload && state_d != S_LOAD_KEY) reload_d = 1'b1;
    end

`ifdef BYTE_TIMEOUT_EN
    gap_d = '0;
    if ((state_q == S_LOAD_KEY || state_q == S_LOAD_DATA) && cnt_q != 5'd0 &&
        !rx_valid && !key_reload) begin
      if (gap_q == 32'(IDLE_TIMEOUT - 1)) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        gap_d = gap_q + 32'd1;
      end
    end
`endif
  end

  always_comb begin
    aes_start = (state_q == S_START);
    tx_valid  = (state_q == S_SEND);
    tx_byte   = 8'h00;
    if (state_q == S_SEND) begin
      for (int i = 0; i < 16; i++) begin
        if (idx_q == 4'(i)) tx_byte = res_q[127-8*i -: 8];
      end
    end
    busy      = !((state_q == S_LOAD_KEY || state_q == S_LOAD_DATA) && cnt_q == 5'd0);
    err       = err_q;
    aes_key   = key_q;
    aes_data  = data_q;
    dbg_state = state_q;
  end

endmodule
